// File: rtl/clock_ctrl.sv
// clock_ctrl: tick dividers, button conditioning and mode FSM for a clock display.
// Optional feature macro: CLOCK_CTRL_PAUSE_EN enables the pause button and PAUSED state.
module clock_ctrl #(
    parameter int unsigned DIV_FAST   = 500000,
    parameter int unsigned DIV_2HZ    = 50000000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_sel,
    input  logic btn_adj,
    input  logic btn_pause,
    output logic tick_fast,
    output logic tick_2hz,
    output logic sec_tick,
    output logic inc_min,
    output logic inc_sec,
    output logic blink_enable,
    output logic blink_state,
    output logic sel_minutes,
    output logic sel_seconds
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] ADJ_MIN = 2'd1;
    localparam logic [1:0] ADJ_SEC = 2'd2;
    localparam logic [1:0] PAUSED  = 2'd3;

`ifdef CLOCK_CTRL_PAUSE_EN
    localparam int unsigned NB = 3;
`else
    localparam int unsigned NB = 2;
`endif

    localparam int unsigned FW = (DIV_FAST > 1) ? $clog2(DIV_FAST) : 1;
    localparam int unsigned SW = (DIV_2HZ > 1) ? $clog2(DIV_2HZ) : 1;
    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [FW-1:0] FAST_LAST = FW'(DIV_FAST - 1);
    localparam logic [SW-1:0] SLOW_LAST = SW'(DIV_2HZ - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    // Button vector layout: [0]=sel, [1]=adj, [2]=pause (when enabled)
    logic [NB-1:0] w_btn;
    logic [NB-1:0] r_sync1;
    logic [NB-1:0] r_sync2;
    logic [NB-1:0] r_deb;
    logic [NB-1:0] r_deb_q;
    logic [NB-1:0] w_press;
    logic [DW-1:0] r_deb_cnt [NB];
    logic          w_sel_press;
    logic          w_adj_press;
    logic          w_pause_press;

`ifdef CLOCK_CTRL_PAUSE_EN
    assign w_btn         = {btn_pause, btn_adj, btn_sel};
    assign w_pause_press = w_press[2];
`else
    logic w_unused_pause;
    assign w_unused_pause = btn_pause;
    assign w_btn          = {btn_adj, btn_sel};
    assign w_pause_press  = 1'b0;
`endif

    assign w_press     = r_deb & ~r_deb_q;
    assign w_sel_press = w_press[0];
    assign w_adj_press = w_press[1];

    // A sample equal to the current level restarts the count; DEB_CYCLES differing samples flip it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_q <= '0;
            for (int unsigned i = 0; i < NB; i++) r_deb_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            for (int unsigned i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    logic [FW-1:0] r_fast_cnt;
    logic [SW-1:0] r_slow_cnt;
    logic          w_fast_wrap;
    logic          w_slow_wrap;

    assign w_fast_wrap = (r_fast_cnt == FAST_LAST);
    assign w_slow_wrap = (r_slow_cnt == SLOW_LAST);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [2:0] w_dec;
    logic       w_inc_min;
    logic       w_inc_sec;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_sel_press) w_state_nxt = ADJ_MIN;
                     else if (w_pause_press) w_state_nxt = PAUSED;
            ADJ_MIN: if (w_sel_press) w_state_nxt = ADJ_SEC;
            ADJ_SEC: if (w_sel_press) w_state_nxt = RUN;
            PAUSED:  if (w_sel_press) w_state_nxt = ADJ_MIN;
                     else if (w_pause_press) w_state_nxt = RUN;
        endcase
    end

    // Decode from next state so outputs follow the press strobe by exactly one cycle
    always_comb begin
        w_dec = 3'b000;
        case (w_state_nxt)
            RUN:     w_dec = 3'b000;
            ADJ_MIN: w_dec = 3'b110;
            ADJ_SEC: w_dec = 3'b101;
            PAUSED:  w_dec = 3'b111;
        endcase
    end

    assign w_inc_min = (r_state == ADJ_MIN) && (w_state_nxt == ADJ_MIN) &&
                       (w_adj_press || (w_slow_wrap && r_deb[1]));
    assign w_inc_sec = (r_state == ADJ_SEC) && (w_state_nxt == ADJ_SEC) &&
                       (w_adj_press || (w_slow_wrap && r_deb[1]));

    logic r_phase;
    logic r_tick_fast;
    logic r_tick_2hz;
    logic r_sec_tick;
    logic r_inc_min;
    logic r_inc_sec;
    logic r_blink_state;
    logic [2:0] r_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fast_cnt    <= '0;
            r_slow_cnt    <= '0;
            r_phase       <= 1'b0;
            r_state       <= RUN;
            r_tick_fast   <= 1'b0;
            r_tick_2hz    <= 1'b0;
            r_sec_tick    <= 1'b0;
            r_inc_min     <= 1'b0;
            r_inc_sec     <= 1'b0;
            r_blink_state <= 1'b1;
            r_dec         <= 3'b000;
        end else begin
            r_fast_cnt    <= w_fast_wrap ? '0 : r_fast_cnt + FW'(1);
            r_slow_cnt    <= w_slow_wrap ? '0 : r_slow_cnt + SW'(1);
            r_phase       <= r_phase ^ w_slow_wrap;
            r_state       <= w_state_nxt;
            r_tick_fast   <= w_fast_wrap;
            r_tick_2hz    <= w_slow_wrap;
            r_sec_tick    <= w_slow_wrap && r_phase && (w_state_nxt == RUN);
            r_inc_min     <= w_inc_min;
            r_inc_sec     <= w_inc_sec;
            r_dec         <= w_dec;
            if (w_state_nxt != r_state)
                r_blink_state <= 1'b1;
            else if (w_slow_wrap)
                r_blink_state <= ~r_blink_state;
        end
    end

    assign tick_fast    = r_tick_fast;
    assign tick_2hz     = r_tick_2hz;
    assign sec_tick     = r_sec_tick;
    assign inc_min      = r_inc_min;
    assign inc_sec      = r_inc_sec;
    assign blink_state  = r_blink_state;
    assign blink_enable = r_dec[2];
    assign sel_minutes  = r_dec[1];
    assign sel_seconds  = r_dec[0];

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with DIV_FAST=4, DIV_2HZ=10, DEB_CYCLES=3.
// Cycle index n counts falling edges since reset release; outputs are sampled there.
module tb_clock_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic btn_sel;
    logic btn_adj;
    logic btn_pause;
    logic tick_fast;
    logic tick_2hz;
    logic sec_tick;
    logic inc_min;
    logic inc_sec;
    logic blink_enable;
    logic blink_state;
    logic sel_minutes;
    logic sel_seconds;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int          n     = 0;
    int          cs;
    int          cm;

`ifdef CLOCK_CTRL_PAUSE_EN
    localparam logic [2:0] DEC_AFTER_PAUSE = 3'b111;
    localparam logic       SEC_IN_PAUSE    = 1'b0;
`else
    localparam logic [2:0] DEC_AFTER_PAUSE = 3'b000;
    localparam logic       SEC_IN_PAUSE    = 1'b1;
`endif

    clock_ctrl #(
        .DIV_FAST   (4),
        .DIV_2HZ    (10),
        .DEB_CYCLES (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_sel      (btn_sel),
        .btn_adj      (btn_adj),
        .btn_pause    (btn_pause),
        .tick_fast    (tick_fast),
        .tick_2hz     (tick_2hz),
        .sec_tick     (sec_tick),
        .inc_min      (inc_min),
        .inc_sec      (inc_sec),
        .blink_enable (blink_enable),
        .blink_state  (blink_state),
        .sel_minutes  (sel_minutes),
        .sel_seconds  (sel_seconds)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (n=%0d): got=%0h expected=%0h", tag, n, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        n++;
    endtask

    function automatic logic [2:0] dec();
        return {blink_enable, sel_minutes, sel_seconds};
    endfunction

    // Hold long enough to debounce (state visible on the 6th sample), then fully release
    task automatic press(input logic s, input logic p);
        btn_sel   = s;
        btn_pause = p;
        repeat (6) cyc();
        btn_sel   = 1'b0;
        btn_pause = 1'b0;
        repeat (8) cyc();
    endtask

    initial begin
        rst       = 1'b1;
        btn_sel   = 1'b0;
        btn_adj   = 1'b0;
        btn_pause = 1'b0;
        repeat (3) cyc();
        check("rst_dec", dec(), 3'b000);
        check("rst_blink", blink_state, 1'b1);
        check("rst_strobes", {tick_fast, tick_2hz, sec_tick, inc_min, inc_sec}, 5'b0);

        rst = 1'b0;
        n   = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            check("tick_fast", tick_fast, (n % 4) == 0);
            check("tick_2hz", tick_2hz, (n % 10) == 0);
            check("sec_tick", sec_tick, (n % 20) == 0);
            check("blink_run", blink_state, ((n / 10) % 2) == 0);
        end

        btn_sel = 1'b1;
        repeat (2) cyc();
        btn_sel = 1'b0;
        repeat (8) cyc();
        check("glitch_dec", dec(), 3'b000);

        btn_sel = 1'b1;
        repeat (5) cyc();
        check("sel_latency", dec(), 3'b000);
        cyc();
        check("sel_adjmin", dec(), 3'b110);
        check("blink_forced", blink_state, 1'b1);
        repeat (4) cyc();
        check("blink_toggle", blink_state, 1'b0);
        btn_sel = 1'b0;

        while (n < 74) cyc();
        btn_adj = 1'b1;
        while (n < 120) begin
            cyc();
            if (n == 109) btn_adj = 1'b0;
            check("inc_min_hold", inc_min, (n == 80) || (n == 90) || (n == 100) || (n == 110));
            check("inc_sec_in_min", inc_sec, 1'b0);
            check("sec_in_adj", sec_tick, 1'b0);
        end

        press(1'b1, 1'b0);
        check("adjmin_to_adjsec", dec(), 3'b101);
        press(1'b1, 1'b0);
        check("adjsec_to_run", dec(), 3'b000);
        press(1'b1, 1'b0);
        check("run_to_adjmin", dec(), 3'b110);
        press(1'b1, 1'b0);
        check("to_adjsec", dec(), 3'b101);

        btn_adj = 1'b1;
        cs = 0;
        cm = 0;
        repeat (15) begin
            cyc();
            cs += int'(inc_sec);
            cm += int'(inc_min);
        end
        check("inc_sec_seen", cs > 0, 1'b1);
        check("inc_min_in_sec", cm, 0);

        rst = 1'b1;
        cyc();
        check("midrst_dec", dec(), 3'b000);
        check("midrst_strobes", {tick_fast, tick_2hz, sec_tick, inc_min, inc_sec}, 5'b0);
        check("midrst_blink", blink_state, 1'b1);
        btn_sel = 1'b1;
        cyc();
        rst = 1'b0;
        n   = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            check("post_rst_fast", tick_fast, (n % 4) == 0);
            check("post_rst_2hz", tick_2hz, (n % 10) == 0);
            check("post_rst_inc_min", inc_min, n == 10);
            if (n == 5) check("held_sel_latency", dec(), 3'b000);
            if (n == 6) check("held_sel_adjmin", dec(), 3'b110);
            if (n == 10) check("post_rst_blink", blink_state, 1'b0);
        end
        btn_sel = 1'b0;
        btn_adj = 1'b0;
        repeat (8) cyc();

        press(1'b0, 1'b1);
        check("pause_ignored_adj", dec(), 3'b110);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("back_to_run", dec(), 3'b000);
        press(1'b1, 1'b1);
        check("sel_wins", dec(), 3'b110);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("run_again", dec(), 3'b000);

        press(1'b0, 1'b1);
        check("pause_dec", dec(), DEC_AFTER_PAUSE);
        cs = 0;
        repeat (25) begin
            cyc();
            cs += int'(sec_tick);
        end
        check("sec_in_pause", cs > 0, SEC_IN_PAUSE);
        press(1'b0, 1'b1);
        check("unpause_dec", dec(), 3'b000);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("pause_sel_adjmin", dec(), 3'b110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
